pc_trace_buffer: RTL and testbench

- Hardware circular log of the most recent program-counter values retired by the CPU.
- It is the writer counterpart of the bench-side PC dump: the CPU core pushes PCs into the buffer, a pass/fail detector freezes it, and a debug or readout path reads entries back oldest-to-newest.
- Sits beside the CPU inside the top module. Snoops the PC and a retire strobe, and exposes a registered indexed read port.

---
 rtl/pc_trace_buffer_if.sv | 29 ++
 rtl/pc_trace_buffer.sv | 92 +++++++++
 tb/tb_pc_trace_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pc_trace_buffer_if.sv
// Trace port bundle for pc_trace_buffer: PC snoop and control from the CPU side,
// indexed readout and status back to the debug side.
interface pc_trace_buffer_if #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pcIn;
  logic             pcValid;
  logic             freeze;
  logic             clear;
  logic [PTR_W-1:0] rdIdx;
  logic [XLEN-1:0]  rdData;
  logic [CNT_W-1:0] count;
  logic             frozen;
  logic             wrapped;

  modport master (
    output pcIn, pcValid, freeze, clear, rdIdx,
    input  rdData, count, frozen, wrapped
  );

  modport slave (
    input  pcIn, pcValid, freeze, clear, rdIdx,
    output rdData, count, frozen, wrapped
  );
endinterface

// File: rtl/pc_trace_buffer.sv
// Circular log of the most recent retired PCs, freezable by a fail detector and
// read back oldest-first. Optional macro TRACE_DEDUP_EN drops repeats of the last logged PC.
module pc_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              reset,
  pc_trace_buffer_if.slave  trace
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {LOGGING = 1'b0, FROZEN = 1'b1} state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             wrapped;
  logic [XLEN-1:0]  rd_data;
  logic [XLEN-1:0]  mem [DEPTH];

  logic             dup;
  logic             wr_en;
  logic [PTR_W-1:0] oldest;
  logic [PTR_W-1:0] rd_addr;

  // Once full, the slot about to be overwritten is the oldest one.
  assign oldest  = (count == FULL) ? wr_ptr : '0;
  assign rd_addr = oldest + trace.rdIdx;
  assign wr_en   = trace.pcValid && (state == LOGGING) && !trace.clear && !dup;

`ifdef TRACE_DEDUP_EN
  logic [XLEN-1:0] last_pc;
  logic            last_valid;

  assign dup = last_valid && (trace.pcIn == last_pc);

  always_ff @(posedge clk) begin
    if (reset || trace.clear) begin
      last_valid <= 1'b0;
    end else if (wr_en) begin
      last_pc    <= trace.pcIn;
      last_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // NOTE: storage is deliberately left out of reset; count alone decides which
  // entries are meaningful, so a reset network on the array would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= trace.pcIn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOGGING;
      wr_ptr  <= '0;
      count   <= '0;
      wrapped <= 1'b0;
    end else if (trace.clear) begin
      state   <= LOGGING;
      wr_ptr  <= '0;
      count   <= '0;
      wrapped <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == FULL) wrapped <= 1'b1;
        else               count   <= count + 1'b1;
      end
      // The write in the freeze edge still lands, so the failing PC is kept.
      if (trace.freeze) state <= FROZEN;
    end
  end

  // NOTE: non-blocking assignment here means the read sees pre-edge count and
  // pointer even when a write or clear happens in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                              rd_data <= '0;
    else if ({1'b0, trace.rdIdx} < count)   rd_data <= mem[rd_addr];
    else                                    rd_data <= '0;
  end

  assign trace.rdData  = rd_data;
  assign trace.count   = count;
  assign trace.frozen  = (state == FROZEN);
  assign trace.wrapped = wrapped;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed self-checking bench for pc_trace_buffer (DEPTH=16, XLEN=32); expected
// values are hand-computed and adjust for TRACE_DEDUP_EN when it is defined.
module tb_pc_trace_buffer;
  localparam int DEPTH = 16;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  pc_trace_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) tif ();

  pc_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .trace (tif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the current inputs; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_pc(input logic [XLEN-1:0] pc);
    tif.pcIn    = pc;
    tif.pcValid = 1'b1;
    tick();
    tif.pcValid = 1'b0;
  endtask

  task automatic do_clear();
    tif.clear = 1'b1;
    tick();
    tif.clear = 1'b0;
  endtask

  task automatic read_check(input string tag, input int idx, input logic [XLEN-1:0] exp);
    tif.rdIdx = idx[3:0];
    tick();
    check(tag, tif.rdData, exp);
  endtask

  initial begin
    reset       = 1'b1;
    tif.pcIn    = '0;
    tif.pcValid = 1'b0;
    tif.freeze  = 1'b0;
    tif.clear   = 1'b0;
    tif.rdIdx   = '0;
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count",   32'(tif.count), 32'd0);
    check("rst_frozen",  32'(tif.frozen), 32'd0);
    check("rst_wrapped", 32'(tif.wrapped), 32'd0);
    check("rst_rddata",  tif.rdData, 32'd0);

    // Basic fill; the third write overlaps a read of idx 2 that must see old count
    log_pc(32'h00);
    log_pc(32'h04);
    tif.rdIdx = 4'd2;
    log_pc(32'h08);
    check("same_cycle_rd", tif.rdData, 32'd0);
    check("fill_count",   32'(tif.count), 32'd3);
    check("fill_wrapped", 32'(tif.wrapped), 32'd0);
    read_check("fill_rd0", 0, 32'h00);
    read_check("fill_rd1", 1, 32'h04);
    read_check("fill_rd2", 2, 32'h08);
    read_check("fill_rd3", 3, 32'h00);

    // Wrap-around from empty with 20 writes
    do_clear();
    for (int k = 0; k < 20; k++) log_pc(32'h100 + 32'(4 * k));
    check("wrap_count",   32'(tif.count), 32'd16);
    check("wrap_wrapped", 32'(tif.wrapped), 32'd1);
    read_check("wrap_rd0",  0,  32'h110);
    read_check("wrap_rd1",  1,  32'h114);
    read_check("wrap_rd15", 15, 32'h14C);

    // Freeze captures the failing PC, later writes ignored
    do_clear();
    check("clr_wrapped", 32'(tif.wrapped), 32'd0);
    log_pc(32'h40);
    log_pc(32'h44);
    tif.freeze = 1'b1;
    log_pc(32'h48);
    tif.freeze = 1'b0;
    check("frz_frozen", 32'(tif.frozen), 32'd1);
    log_pc(32'h4C);
    check("frz_count",  32'(tif.count), 32'd3);
    check("frz_sticky", 32'(tif.frozen), 32'd1);
    read_check("frz_rd2", 2, 32'h48);
    read_check("frz_rd3", 3, 32'h00);

    // Clear beats freeze and pcValid
    tif.clear  = 1'b1;
    tif.freeze = 1'b1;
    log_pc(32'hEE);
    tif.clear  = 1'b0;
    tif.freeze = 1'b0;
    check("cf_count",   32'(tif.count), 32'd0);
    check("cf_frozen",  32'(tif.frozen), 32'd0);
    check("cf_wrapped", 32'(tif.wrapped), 32'd0);
    log_pc(32'hA4);
    read_check("cf_rd0", 0, 32'hA4);

    // Reset mid-operation with count=10 and a write in the same edge
    do_clear();
    for (int k = 0; k < 10; k++) log_pc(32'h200 + 32'(4 * k));
    check("pre_rst_count", 32'(tif.count), 32'd10);
    read_check("pre_rst_rd0", 0, 32'h200);
    tif.freeze = 1'b1;
    tick();
    tif.freeze = 1'b0;
    reset = 1'b1;
    log_pc(32'h300);
    reset = 1'b0;
    check("mid_rst_count",  32'(tif.count), 32'd0);
    check("mid_rst_rddata", tif.rdData, 32'd0);
    check("mid_rst_frozen", 32'(tif.frozen), 32'd0);
    log_pc(32'h8);
    check("post_rst_count", 32'(tif.count), 32'd1);
    read_check("post_rst_rd0", 0, 32'h8);

    // Repeated PCs: collapsed only with dedup enabled
    do_clear();
    log_pc(32'h20);
    log_pc(32'h20);
    log_pc(32'h20);
    log_pc(32'h24);
    log_pc(32'h20);
`ifdef TRACE_DEDUP_EN
    check("dd_count", 32'(tif.count), 32'd3);
    read_check("dd_rd0", 0, 32'h20);
    read_check("dd_rd1", 1, 32'h24);
    read_check("dd_rd2", 2, 32'h20);
`else
    check("dd_count", 32'(tif.count), 32'd5);
    read_check("dd_rd1", 1, 32'h20);
    read_check("dd_rd3", 3, 32'h24);
    read_check("dd_rd4", 4, 32'h20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
